mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: `clk` rising edge; `rst` asynchronous, active-high.
REQ-002 SHALL expose ports, one per line:
  clk  in  1  system clock
  rst  in  1  async active-high reset
  opcode  in  7  IR[6:0]
  funct7  in  7  IR[31:25]
  mem_ready  in  1  memory handshake; access completes in a cycle with mem_ready=1
  alu_zero  in  1  zero flag from the datapath ALU
  pc_we  out  1  unconditional PC write
  ir_we  out  1  instruction register write
  target_we  out  1  branch-target register write
  alu_op  out  1  0=add (`ALU_ADD`), 1=sub (`ALU_SUB`)
  alu_beq  out  1  ALU branch-compare enable
  alu_jal  out  1  ALU jump force-zero
  alu_src1_sel  out  1  0=PC, 1=rs1
  alu_src2_sel  out  2  00=rs2, 01=imm, 10=const 4
  pc_sel  out  1  0=ALU result, 1=target register
  reg_we  out  1  register file write
  wb_sel  out  2  00=ALU result, 01=MDR, 10=PC (link)
  mem_re  out  1  memory read request
  mem_we  out  1  memory write request
  iord  out  1  0=address PC, 1=address ALU-out register
  illegal  out  1  sticky unsupported-opcode flag
  state  out  4  current state (debug)

Function
REQ-003 SHALL be a multi-cycle control FSM with states IF=0, ID=1, EX_R=2, EX_I=3, EX_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, EX_BEQ=9, EX_JAL=10, HALT=15; all other codes SHALL go to IF.
REQ-004 IF: mem_re=1, iord=0, alu_src1_sel=0, alu_src2_sel=10, alu_op=0, pc_sel=0; ir_we and pc_we SHALL be 1 only in the cycle mem_ready=1; the FSM SHALL stay in IF while mem_ready=0 and go to ID when mem_ready=1.
REQ-005 ID: alu_src1_sel=0, alu_src2_sel=01, alu_op=0, target_we=1 (computes PC-4+imm). The datapath supplies the PC-4 correction. Next state by opcode:
  0110011 with funct7 = 0000000 or 0100000: EX_R.
  0010011: EX_I.
  0000011 or 0100011: EX_ADDR.
  1100011: EX_BEQ.
  1101111: EX_JAL.
  Anything else: HALT.
REQ-006 EX_R: alu_src1_sel=1, alu_src2_sel=00, alu_op=funct7[5]. EX_I: alu_src1_sel=1, alu_src2_sel=01, alu_op=0. Both SHALL go to WB_ALU.
REQ-007 WB_ALU: reg_we=1, wb_sel=00, then IF. WB_MEM: reg_we=1, wb_sel=01, then IF.
REQ-008 EX_ADDR: alu_src1_sel=1, alu_src2_sel=01, alu_op=0. Next state: MEM_RD if opcode=0000011, MEM_WR if opcode=0100011.
REQ-009 MEM_RD: mem_re=1, iord=1. It SHALL wait for mem_ready, then go to WB_MEM. MEM_WR: mem_we=1, iord=1. It SHALL wait for mem_ready, then go to IF.
REQ-010 EX_BEQ: alu_src1_sel=1, alu_src2_sel=00, alu_op=1, alu_beq=1, pc_sel=1; pc_we=alu_zero in the same cycle; then IF.
REQ-011 EX_JAL: alu_jal=1, pc_sel=1, pc_we=1, reg_we=1, wb_sel=10; then IF.
REQ-012 HALT: illegal=1 and every other strobe 0; the FSM SHALL remain in HALT until rst.
REQ-013 Any output not listed for a state SHALL be 0.
REQ-014 Outputs SHALL be combinational from state, with mem_ready/alu_zero gating only where stated. Each non-memory state SHALL last exactly 1 cycle.
REQ-015 A memory state SHALL hold mem_re/mem_we steady and assert no write strobe until mem_ready=1. mem_ready during a non-memory state SHALL be ignored.
REQ-016 Instruction latencies with mem_ready always 1:
  R/I: 4 cycles.
  lw: 5 cycles.
  sw: 4 cycles.
  beq: 3 cycles.
  jal: 3 cycles.

Reset
REQ-017 rst=1 SHALL force state=IF immediately, clear illegal, and force every output to 0 while rst is high.
REQ-018 The first fetch strobes SHALL appear in the first cycle after rst deasserts.
REQ-019 rst asserted mid-instruction, including during a memory wait, SHALL abort the instruction with no further write strobe.

Verification
REQ-020 add, mem_ready=1 -> states 0,1,2,7,0; alu_op=0 in EX_R; exactly one reg_we pulse, with wb_sel=00.
REQ-021 sub (funct7=0100000) -> alu_op=1 in EX_R; result written in WB_ALU.
REQ-022 lw with mem_ready=0 for 3 cycles in MEM_RD -> mem_re=1, iord=1 held for 4 cycles; then WB_MEM with reg_we=1, wb_sel=01. No reg_we during the wait.
REQ-023 beq, once with alu_zero=1 and once with alu_zero=0 -> pc_we=1/pc_sel=1 when taken, pc_we=0 when not taken; alu_beq=1, alu_op=1 in EX_BEQ; 3 cycles each.
REQ-024 jal -> EX_JAL with alu_jal=1, pc_we=1, reg_we=1, wb_sel=10; next state IF.
REQ-025 opcode=1111111 -> HALT with illegal=1 and no strobes for 10 cycles. Asynchronous rst pulse mid-cycle -> state=0 and illegal=0 immediately; fetch resumes.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for a small RV32 subset
// (R/I ALU ops, lw, sw, beq, jal), with a sticky illegal-opcode halt.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       target_we,
  output logic       alu_op,
  output logic       alu_beq,
  output logic       alu_jal,
  output logic       alu_src1_sel,
  output logic [1:0] alu_src2_sel,
  output logic       pc_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       mem_re,
  output logic       mem_we,
  output logic       iord,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IF = 4'd0, ID = 4'd1, EX_R = 4'd2, EX_I = 4'd3, EX_ADDR = 4'd4, MEM_RD = 4'd5,
    MEM_WR = 4'd6, WB_ALU = 4'd7, WB_MEM = 4'd8, EX_BEQ = 4'd9, EX_JAL = 4'd10, HALT = 4'd15
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  state_t cur, nxt;
  logic r_ok;
  assign r_ok = opcode == OP_R && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
  assign state = cur;
  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= IF;
    else cur <= nxt;
  always_comb begin
    nxt = IF;
    pc_we = 1'b0;
    ir_we = 1'b0;
    target_we = 1'b0;
    alu_op = 1'b0;
    alu_beq = 1'b0;
    alu_jal = 1'b0;
    alu_src1_sel = 1'b0;
    alu_src2_sel = 2'b00;
    pc_sel = 1'b0;
    reg_we = 1'b0;
    wb_sel = 2'b00;
    mem_re = 1'b0;
    mem_we = 1'b0;
    iord = 1'b0;
    illegal = 1'b0;
    case (cur)
      IF: begin
        nxt = mem_ready ? ID : IF;
        mem_re = 1'b1;
        alu_src2_sel = 2'b10;
        ir_we = mem_ready;
        pc_we = mem_ready;
      end
      ID: begin
        nxt = r_ok ? EX_R : opcode == OP_I ? EX_I : (opcode == OP_LW || opcode == OP_SW) ? EX_ADDR :
              opcode == OP_BEQ ? EX_BEQ : opcode == OP_JAL ? EX_JAL : HALT;
        alu_src2_sel = 2'b01;
        target_we = 1'b1;
      end
      EX_R: begin
        nxt = WB_ALU;
        alu_src1_sel = 1'b1;
        alu_op = funct7[5];
      end
      EX_I: begin
        nxt = WB_ALU;
        alu_src1_sel = 1'b1;
        alu_src2_sel = 2'b01;
      end
      EX_ADDR: begin
        nxt = opcode == OP_LW ? MEM_RD : opcode == OP_SW ? MEM_WR : IF;
        alu_src1_sel = 1'b1;
        alu_src2_sel = 2'b01;
      end
      MEM_RD: begin
        nxt = mem_ready ? WB_MEM : MEM_RD;
        mem_re = 1'b1;
        iord = 1'b1;
      end
      MEM_WR: begin
        nxt = mem_ready ? IF : MEM_WR;
        mem_we = 1'b1;
        iord = 1'b1;
      end
      WB_ALU: reg_we = 1'b1;
      WB_MEM: begin
        reg_we = 1'b1;
        wb_sel = 2'b01;
      end
      EX_BEQ: begin
        alu_src1_sel = 1'b1;
        alu_op = 1'b1;
        alu_beq = 1'b1;
        pc_sel = 1'b1;
        pc_we = alu_zero;
      end
      EX_JAL: begin
        alu_jal = 1'b1;
        pc_sel = 1'b1;
        pc_we = 1'b1;
        reg_we = 1'b1;
        wb_sel = 2'b10;
      end
      HALT: begin
        nxt = HALT;
        illegal = 1'b1;
      end
      default: nxt = IF;
    endcase
    // Reset already holds cur at IF; this also silences IF's fetch strobes while rst is high.
    if (rst) begin
      pc_we = 1'b0;
      ir_we = 1'b0;
      mem_re = 1'b0;
      alu_src2_sel = 2'b00;
    end
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven per-cycle vectors with a scoreboard queue, plus
// hand-written memory-wait sequences of random length.
module tb_mc_control;
  logic clk = 1'b0, rst = 1'b0, mem_ready = 1'b0, alu_zero = 1'b0;
  logic [6:0] opcode = 7'd0, funct7 = 7'd0;
  logic pc_we, ir_we, target_we, alu_op, alu_beq, alu_jal, alu_src1_sel, pc_sel, reg_we;
  logic mem_re, mem_we, iord, illegal;
  logic [1:0] alu_src2_sel, wb_sel;
  logic [3:0] state;
  typedef struct packed {
    logic pc_we, ir_we, target_we, alu_op, alu_beq, alu_jal, src1;
    logic [1:0] src2;
    logic pc_sel, reg_we;
    logic [1:0] wb_sel;
    logic mem_re, mem_we, iord, illegal;
    logic [3:0] st;
  } outs_t;
  typedef struct {
    logic rst;
    logic [6:0] op, f7;
    logic mr, az;
    outs_t exp;
  } vec_t;
  localparam outs_t O_RST  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd0};
  localparam outs_t O_IF   = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,4'd0};
  localparam outs_t O_IFW  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,4'd0};
  localparam outs_t O_ID   = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd1};
  localparam outs_t O_ADD  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd2};
  localparam outs_t O_SUB  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd2};
  localparam outs_t O_EXI  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd3};
  localparam outs_t O_ADDR = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd4};
  localparam outs_t O_MRD  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,4'd5};
  localparam outs_t O_MWR  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,4'd6};
  localparam outs_t O_WBA  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,4'd7};
  localparam outs_t O_WBM  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,4'd8};
  localparam outs_t O_BEQT = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,2'b00,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd9};
  localparam outs_t O_BEQN = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,2'b00,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,4'd9};
  localparam outs_t O_JAL  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,4'd10};
  localparam outs_t O_HALT = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,4'd15};
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, BAD = 7'b1111111, SUBF = 7'b0100000;
  vec_t tbl[$];
  outs_t sb[$];
  int total = 0, passed = 0;
  mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .pc_we(pc_we), .ir_we(ir_we), .target_we(target_we), .alu_op(alu_op), .alu_beq(alu_beq),
    .alu_jal(alu_jal), .alu_src1_sel(alu_src1_sel), .alu_src2_sel(alu_src2_sel), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .mem_re(mem_re), .mem_we(mem_we), .iord(iord),
    .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [6:0] op, input logic [6:0] f7, input logic mr, input logic az, input outs_t e);
    vec_t v;
    v.rst = r; v.op = op; v.f7 = f7; v.mr = mr; v.az = az; v.exp = e;
    tbl.push_back(v);
  endtask
  task automatic step(input string name, input logic r, input logic [6:0] op, input logic [6:0] f7,
                      input logic mr, input logic az, input outs_t e);
    outs_t got, want;
    @(negedge clk);
    rst = r; opcode = op; funct7 = f7; mem_ready = mr; alu_zero = az;
    sb.push_back(e);
    #1;
    got = {pc_we, ir_we, target_we, alu_op, alu_beq, alu_jal, alu_src1_sel, alu_src2_sel, pc_sel,
           reg_we, wb_sel, mem_re, mem_we, iord, illegal, state};
    want = sb.pop_front();
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask
  task automatic lw_wait(input int n);
    step("lw_if", 1'b0, LW, 7'd0, 1'b1, 1'b0, O_IF);
    step("lw_id", 1'b0, LW, 7'd0, 1'b1, 1'b0, O_ID);
    step("lw_addr", 1'b0, LW, 7'd0, 1'b0, 1'b0, O_ADDR);
    for (int k = 0; k < n; k++) step("lw_wait", 1'b0, LW, 7'd0, 1'b0, 1'b1, O_MRD);
    step("lw_rdy", 1'b0, LW, 7'd0, 1'b1, 1'b0, O_MRD);
    step("lw_wb", 1'b0, LW, 7'd0, 1'b0, 1'b0, O_WBM);
  endtask
  task automatic sw_wait(input int n);
    step("sw_if", 1'b0, SW, 7'd0, 1'b1, 1'b0, O_IF);
    step("sw_id", 1'b0, SW, 7'd0, 1'b1, 1'b0, O_ID);
    step("sw_addr", 1'b0, SW, 7'd0, 1'b1, 1'b0, O_ADDR);
    for (int k = 0; k < n; k++) step("sw_wait", 1'b0, SW, 7'd0, 1'b0, 1'b0, O_MWR);
    step("sw_rdy", 1'b0, SW, 7'd0, 1'b1, 1'b0, O_MWR);
  endtask
  initial begin
    add(1'b1, R, 7'd0, 1'b1, 1'b0, O_RST);
    add(1'b1, R, 7'd0, 1'b1, 1'b0, O_RST);
    add(1'b0, R, 7'd0, 1'b0, 1'b0, O_IFW);
    add(1'b0, R, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, R, 7'd0, 1'b0, 1'b0, O_ID);
    add(1'b0, R, 7'd0, 1'b1, 1'b0, O_ADD);
    add(1'b0, R, 7'd0, 1'b1, 1'b0, O_WBA);
    add(1'b0, R, SUBF, 1'b1, 1'b0, O_IF);
    add(1'b0, R, SUBF, 1'b1, 1'b0, O_ID);
    add(1'b0, R, SUBF, 1'b1, 1'b0, O_SUB);
    add(1'b0, R, SUBF, 1'b1, 1'b0, O_WBA);
    add(1'b0, I, SUBF, 1'b1, 1'b0, O_IF);
    add(1'b0, I, SUBF, 1'b1, 1'b0, O_ID);
    add(1'b0, I, SUBF, 1'b1, 1'b0, O_EXI);
    add(1'b0, I, SUBF, 1'b1, 1'b0, O_WBA);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_ID);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_ADDR);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_MRD);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_WBM);
    add(1'b0, BEQ, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, BEQ, 7'd0, 1'b1, 1'b0, O_ID);
    add(1'b0, BEQ, 7'd0, 1'b1, 1'b1, O_BEQT);
    add(1'b0, BEQ, 7'd0, 1'b1, 1'b1, O_IF);
    add(1'b0, BEQ, 7'd0, 1'b1, 1'b1, O_ID);
    add(1'b0, BEQ, 7'd0, 1'b1, 1'b0, O_BEQN);
    add(1'b0, JAL, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, JAL, 7'd0, 1'b0, 1'b0, O_ID);
    add(1'b0, JAL, 7'd0, 1'b0, 1'b0, O_JAL);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_ID);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_ADDR);
    add(1'b0, LW, 7'd0, 1'b0, 1'b0, O_MRD);
    add(1'b1, LW, 7'd0, 1'b1, 1'b0, O_RST);
    add(1'b0, LW, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, R, 7'b0000001, 1'b1, 1'b0, O_ID);
    add(1'b0, R, 7'b0000001, 1'b1, 1'b0, O_HALT);
    add(1'b1, R, 7'd0, 1'b1, 1'b0, O_RST);
    add(1'b0, BAD, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, BAD, 7'd0, 1'b1, 1'b0, O_ID);
    for (int k = 0; k < 10; k++) add(1'b0, BAD, 7'd0, k[0], ~k[0], O_HALT);
    add(1'b1, BAD, 7'd0, 1'b1, 1'b1, O_RST);
    add(1'b0, R, 7'd0, 1'b1, 1'b0, O_IF);
    add(1'b0, R, 7'd0, 1'b1, 1'b0, O_ID);
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].op, tbl[i].f7, tbl[i].mr, tbl[i].az, tbl[i].exp);
    step("r_ex", 1'b0, R, 7'd0, 1'b1, 1'b0, O_ADD);
    step("r_wb", 1'b0, R, 7'd0, 1'b1, 1'b0, O_WBA);
    lw_wait(3);
    lw_wait($urandom_range(1, 6));
    sw_wait($urandom_range(1, 6));
    step("halt_if", 1'b0, BAD, 7'd0, 1'b1, 1'b0, O_IF);
    step("halt_id", 1'b0, BAD, 7'd0, 1'b1, 1'b0, O_ID);
    step("halt", 1'b0, BAD, 7'd0, 1'b1, 1'b0, O_HALT);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 total++;
    if (state === 4'd0 && illegal === 1'b0 && mem_re === 1'b0 && pc_we === 1'b0) passed++;
    else $display("FAIL async_rst: state %0d illegal %b mem_re %b pc_we %b, expected 0 0 0 0", state, illegal, mem_re, pc_we);
    step("post_rst", 1'b0, R, 7'd0, 1'b1, 1'b0, O_IF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
